// File: rtl/lane_runner_engine.sv
// lane_runner_engine: game-state engine for the lane-dodger VGA demo.
// Owns obstacle motion, player lane moves, collision, score, lives and the game FSM.
// Optional feature macro: OBSTACLE_LFSR_EN (pseudo-random respawn X from a 10-bit LFSR).
module lane_runner_engine #(
    parameter int unsigned NUM_LANES  = 6,
    parameter int unsigned LANE_Y0    = 60,
    parameter int unsigned LANE_PITCH = 60,
    parameter int unsigned PLAYER_X   = 320,
    parameter int unsigned HIT_HALF_W = 30,
    parameter int unsigned H_RES      = 640,
    parameter int unsigned WIN_SCORE  = 10,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned HIT_TICKS  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic                         start,
    input  logic                         btn_up,
    input  logic                         btn_down,
    output logic [$clog2(NUM_LANES)-1:0] player_lane,
    output logic [9:0]                   player_y,
    output logic [10*NUM_LANES-1:0]      obs_x,
    output logic [3:0]                   score,
    output logic [2:0]                   lives,
    output logic [1:0]                   state,
    output logic                         hit,
    output logic                         win
);

    localparam int unsigned LW      = $clog2(NUM_LANES);
    localparam int unsigned CW      = $clog2(HIT_TICKS + 1);
    localparam int unsigned SPACING = H_RES / NUM_LANES;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HIT  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [9:0]      py_q, py_d;
    logic [9:0]      obs_q [NUM_LANES];
    logic [9:0]      obs_d [NUM_LANES];
    logic [3:0]      score_q, score_d;
    logic [2:0]      lives_q, lives_d;
    logic            hit_q, hit_d;
    logic            win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_prev_q, up_prev_q, dn_prev_q;

    logic            start_rise, up_rise, dn_rise;
    logic [9:0]      respawn_x;
    logic [9:0]      nx [NUM_LANES];
    logic [3:0]      pass_cnt;
    logic [4:0]      score_sum;
    logic [3:0]      score_sat;
    logic [10:0]     px;
    logic            collide;

    function automatic logic [9:0] lane_y(input logic [LW-1:0] l);
        return 10'(LANE_Y0 + 32'(l) * LANE_PITCH);
    endfunction

    assign start_rise = start & ~start_prev_q;
    assign up_rise    = btn_up & ~up_prev_q;
    assign dn_rise    = btn_down & ~dn_prev_q;

`ifdef OBSTACLE_LFSR_EN
    logic [9:0] lfsr_q, lfsr_d;

    // LFSR x^10+x^7+1, advances once per frame tick
    always_comb begin
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        end
    end

    // LFSR register, seeded on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= 10'h2A5;
        else       lfsr_q <= lfsr_d;
    end

    assign respawn_x = {3'b000, lfsr_q[6:0]};
`else
    assign respawn_x = 10'd0;
`endif

    // Preview of one tick of motion: new X per lane, lanes passed, collision in player lane
    always_comb begin
        pass_cnt = 4'd0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            logic [10:0] sum;
            sum = 11'(obs_q[k]) + 11'(1 + (k % 4));
            if (sum >= 11'(H_RES)) begin
                nx[k] = respawn_x;
                if (LW'(k) != lane_q) pass_cnt = pass_cnt + 4'd1;
            end else begin
                nx[k] = sum[9:0];
            end
        end
        px        = {1'b0, nx[lane_q]};
        collide   = (px + 11'(HIT_HALF_W) > 11'(PLAYER_X)) && (px < 11'(PLAYER_X + HIT_HALF_W));
        score_sum = 5'(score_q) + 5'(pass_cnt);
        score_sat = (score_sum >= 5'(WIN_SCORE)) ? 4'(WIN_SCORE) : score_sum[3:0];
    end

    // Game FSM next-state and output logic
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        obs_d   = obs_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        win_d   = win_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_PLAY;
                    cnt_d   = '0;
                    for (int k = 0; k < int'(NUM_LANES); k++) begin
                        obs_d[k] = 10'(k * SPACING);
                    end
                end
            end
            S_PLAY: begin
                if (up_rise && !dn_rise && lane_q != '0) begin
                    lane_d = lane_q - LW'(1);
                end else if (dn_rise && !up_rise && lane_q != LW'(NUM_LANES - 1)) begin
                    lane_d = lane_q + LW'(1);
                end
                if (tick) begin
                    obs_d   = nx;
                    score_d = score_sat;
                    if (collide) begin
                        hit_d         = 1'b1;
                        lives_d       = lives_q - 3'd1;
                        obs_d[lane_q] = respawn_x;
                        state_d       = S_HIT;
                        cnt_d         = '0;
                    end else if (score_sat == 4'(WIN_SCORE)) begin
                        state_d = S_DONE;
                        win_d   = 1'b1;
                    end
                end
            end
            S_HIT: begin
                if (tick) begin
                    if (cnt_q == CW'(HIT_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = (lives_q == 3'd0) ? S_DONE : S_PLAY;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE: begin
                if (start_rise) begin
                    state_d = S_IDLE;
                    score_d = 4'd0;
                    lives_d = 3'(LIVES);
                    win_d   = 1'b0;
                    lane_d  = LW'(NUM_LANES / 2);
                end
            end
            default: state_d = S_IDLE;
        endcase

        py_d = lane_y(lane_d);
    end

    // State and edge-detect registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lane_q       <= LW'(NUM_LANES / 2);
            py_q         <= 10'(LANE_Y0 + (NUM_LANES / 2) * LANE_PITCH);
            for (int k = 0; k < int'(NUM_LANES); k++) obs_q[k] <= 10'd0;
            score_q      <= 4'd0;
            lives_q      <= 3'(LIVES);
            hit_q        <= 1'b0;
            win_q        <= 1'b0;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
            up_prev_q    <= 1'b0;
            dn_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            py_q         <= py_d;
            obs_q        <= obs_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            hit_q        <= hit_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start;
            up_prev_q    <= btn_up;
            dn_prev_q    <= btn_down;
        end
    end

    for (genvar k = 0; k < int'(NUM_LANES); k++) begin : g_obs
        assign obs_x[10*k +: 10] = obs_q[k];
    end

    assign player_lane = lane_q;
    assign player_y    = py_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign state       = state_q;
    assign hit         = hit_q;
    assign win         = win_q;

endmodule

// File: tb/tb_lane_runner_engine.sv
// Randomized bench for lane_runner_engine (default build, respawn at x=0),
// checked every cycle against a game-rule reference model.
module tb_lane_runner_engine;

    localparam int NL = 6;

    logic        clk = 1'b0;
    logic        reset, tick, start, btn_up, btn_down;
    logic [2:0]  player_lane;
    logic [9:0]  player_y;
    logic [10*NL-1:0] obs_x;
    logic [3:0]  score;
    logic [2:0]  lives;
    logic [1:0]  state;
    logic        hit, win;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (game rules in plain integers)
    int m_state, m_lane, m_score, m_lives, m_hit, m_win, m_hticks;
    int m_obs [NL];
    int m_ps, m_pu, m_pd;

    lane_runner_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .btn_up(btn_up), .btn_down(btn_down),
        .player_lane(player_lane), .player_y(player_y), .obs_x(obs_x),
        .score(score), .lives(lives), .state(state), .hit(hit), .win(win)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lane = NL / 2; m_score = 0; m_lives = 3;
        m_hit = 0; m_win = 0; m_hticks = 0;
        m_ps = 0; m_pu = 0; m_pd = 0;
        for (int k = 0; k < NL; k++) m_obs[k] = 0;
    endtask

    // One clock of the game rules, given the inputs applied for that clock
    task automatic model_step(input int t, input int s, input int u, input int d);
        int su, uu, du, passed, px, new_lane;
        int nobs [NL];
        su = s && !m_ps; uu = u && !m_pu; du = d && !m_pd;
        m_hit = 0;
        case (m_state)
            0: if (su) begin
                m_state = 1;
                for (int k = 0; k < NL; k++) m_obs[k] = k * (640 / NL);
            end
            1: begin
                new_lane = m_lane;
                if (uu && !du) new_lane = (m_lane > 0) ? m_lane - 1 : 0;
                if (du && !uu) new_lane = (m_lane < NL - 1) ? m_lane + 1 : NL - 1;
                if (t) begin
                    passed = 0;
                    for (int k = 0; k < NL; k++) begin
                        nobs[k] = m_obs[k] + 1 + (k % 4);
                        if (nobs[k] >= 640) begin
                            nobs[k] = 0;
                            if (k != m_lane) passed++;
                        end
                    end
                    m_score = (m_score + passed > 10) ? 10 : m_score + passed;
                    px = nobs[m_lane];
                    if (px + 30 > 320 && px < 350) begin
                        m_hit = 1;
                        m_lives--;
                        nobs[m_lane] = 0;
                        m_state = 2;
                        m_hticks = 0;
                    end else if (m_score == 10) begin
                        m_state = 3;
                        m_win = 1;
                    end
                    for (int k = 0; k < NL; k++) m_obs[k] = nobs[k];
                end
                m_lane = new_lane;
            end
            2: if (t) begin
                m_hticks++;
                if (m_hticks == 32) m_state = (m_lives == 0) ? 3 : 1;
            end
            default: if (su) begin
                m_state = 0; m_score = 0; m_lives = 3; m_win = 0; m_lane = NL / 2;
            end
        endcase
        m_ps = s; m_pu = u; m_pd = d;
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, ".state"}, 32'(state), 32'(m_state));
        check({pfx, ".lane"},  32'(player_lane), 32'(m_lane));
        check({pfx, ".y"},     32'(player_y), 32'(60 + 60 * m_lane));
        check({pfx, ".score"}, 32'(score), 32'(m_score));
        check({pfx, ".lives"}, 32'(lives), 32'(m_lives));
        check({pfx, ".hit"},   32'(hit), 32'(m_hit));
        check({pfx, ".win"},   32'(win), 32'(m_win));
        for (int k = 0; k < NL; k++) begin
            check($sformatf("%s.obs%0d", pfx, k), 32'(obs_x[10*k +: 10]), 32'(m_obs[k]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; tick = 1'b0; start = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        #1;
        model_reset();
        compare_all("rst_async");
        @(posedge clk); #1;
        compare_all("rst_hold");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int hits_seen, wins_seen;
        hits_seen = 0; wins_seen = 0;
        reset = 1'b1; tick = 1'b0; start = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 24000; i++) begin
            if (i % 6000 == 5999) begin
                do_reset();
            end else begin
                @(negedge clk);
                tick = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 39) == 0) start = ~start;
                if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
                if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
                model_step(int'(tick), int'(start), int'(btn_up), int'(btn_down));
                @(posedge clk); #1;
                compare_all("run");
                if (m_hit == 1) hits_seen++;
                if (m_win == 1 && m_state == 3) wins_seen++;
            end
        end

        $display("Coverage: %0d hits, %0d cycles in won DONE", hits_seen, wins_seen);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
